// File: rtl/mem_dump_pkg.sv
// Shared types and ASCII constants for the memory-dump text streamer.
// The header is stored as one packed string so any character can be picked by index.
package mem_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_LINE = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam int HDR_LEN  = 14;
    localparam int LINE_LEN = 16;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_X     = 8'h78;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [8*HDR_LEN-1:0] HDR_STR = {"Address,Value", ASCII_LF};

    // Character idx of the header line, first character at idx 0.
    function automatic logic [7:0] hdr_char(input logic [3:0] idx);
        logic [7:0] ch;
        ch = 8'h00;
        if (int'(idx) < HDR_LEN) begin
            ch = HDR_STR[8*(HDR_LEN-1-int'(idx)) +: 8];
        end
        return ch;
    endfunction

endpackage

// File: rtl/hex_ascii_enc.sv
// Combinational nibble to lowercase ASCII hex digit ('0'-'9', 'a'-'f').
module hex_ascii_enc (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    always_comb begin
        if (i_nibble < 4'd10) begin
            o_ascii = 8'h30 + {4'h0, i_nibble};
        end else begin
            o_ascii = 8'h57 + {4'h0, i_nibble};
        end
    end

endmodule

// File: rtl/mem_dump_streamer.sv
// Walks a byte-wide data-memory read port and streams the "Address,Value" text dump
// as ASCII bytes over a valid/ready interface.
module mem_dump_streamer
    import mem_dump_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned NUM_BYTES = 65536,
    parameter bit          SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    state_t            r_state;
    logic [3:0]        r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_value;

    logic        w_xfer;
    logic        w_skip;
    logic        w_step;
    logic        w_last_byte;
    logic [3:0]  w_nidx;
    logic [31:0] w_addr32;
    logic [3:0]  w_nib;
    logic [7:0]  w_hex;
    logic [7:0]  w_line_char;

    // Handshake: a byte moves on any cycle with tx_valid && tx_ready; once raised,
    // tx_valid and tx_data hold until that transfer, and tx_valid is purely registered.
    assign w_xfer      = tx_valid && tx_ready;
    assign w_skip      = SKIP_ZERO && (mem_rdata == 8'h00);
    assign w_last_byte = (r_cnt == LAST_CNT);
    assign w_nidx      = r_idx + 4'd1;
    assign w_addr32    = 32'(r_addr);
    assign dbg_state   = r_state;

    // Advance to the next address after a skipped byte or after a line's LF transfers.
    assign w_step = ((r_state == ST_WAIT) && w_skip) ||
                    ((r_state == ST_LINE) && w_xfer && (r_idx == 4'(LINE_LEN - 1)));

    // Line layout: 0 x a7..a0 , 0 x v1 v0 LF  (indices 0..15); look up the next char.
    always_comb begin
        w_nib = 4'h0;
        if ((w_nidx >= 4'd2) && (w_nidx <= 4'd9)) begin
            w_nib = w_addr32[(9 - int'(w_nidx))*4 +: 4];
        end else if (w_nidx == 4'd13) begin
            w_nib = r_value[7:4];
        end else if (w_nidx == 4'd14) begin
            w_nib = r_value[3:0];
        end
    end

    hex_ascii_enc u_hex (
        .i_nibble (w_nib),
        .o_ascii  (w_hex)
    );

    always_comb begin
        w_line_char = w_hex;
        case (w_nidx)
            4'd0, 4'd11: w_line_char = ASCII_ZERO;
            4'd1, 4'd12: w_line_char = ASCII_X;
            4'd10:       w_line_char = ASCII_COMMA;
            4'd15:       w_line_char = ASCII_LF;
            default:     w_line_char = w_hex;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= 4'd0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_value   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_HDR;
                        busy     <= 1'b1;
                        r_idx    <= 4'd0;
                        r_addr   <= ADDR_W'(BASE_ADDR);
                        r_cnt    <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= hdr_char(4'd0);
                    end
                end
                ST_HDR: begin
                    if (w_xfer) begin
                        if (r_idx == 4'(HDR_LEN - 1)) begin
                            tx_valid  <= 1'b0;
                            r_state   <= ST_RD;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= r_addr;
                        end else begin
                            r_idx   <= w_nidx;
                            tx_data <= hdr_char(w_nidx);
                        end
                    end
                end
                ST_RD: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_value <= mem_rdata;
                    if (!w_skip) begin
                        r_state  <= ST_LINE;
                        r_idx    <= 4'd0;
                        tx_valid <= 1'b1;
                        tx_data  <= ASCII_ZERO;
                    end
                end
                ST_LINE: begin
                    if (w_xfer) begin
                        if (r_idx == 4'(LINE_LEN - 1)) begin
                            tx_valid <= 1'b0;
                        end else begin
                            r_idx   <= w_nidx;
                            tx_data <= w_line_char;
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_step) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_last_byte) begin
                    r_state <= ST_FIN;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end else begin
                    r_state   <= ST_RD;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Bench for mem_dump_streamer: three configurations (plain, skip-zero, 4-bit wrapping
// address) driven with random memory contents and sink stalls, checked against a text model.
module tb_mem_dump_streamer;

    localparam int NI = 3;
    localparam int unsigned C_BASE [NI] = '{32'hD51C, 32'h0, 32'hE};
    localparam int          C_N    [NI] = '{4, 4, 3};
    localparam int          C_AW   [NI] = '{16, 16, 4};
    localparam bit          C_SKIP [NI] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI-1:0]        start_v;
    logic [NI-1:0]        ready_v;
    logic [NI-1:0]        busy_v;
    logic [NI-1:0]        done_v;
    logic [NI-1:0]        rd_v;
    logic [NI-1:0]        valid_v;
    logic [NI-1:0][7:0]   data_v;
    logic [NI-1:0][7:0]   rdata_v;
    logic [NI-1:0][15:0]  addr_v;
    logic [NI-1:0][2:0]   st_v;
    logic [3:0]           addr_w4;
    logic [7:0]           mem_v [NI][65536];

    assign addr_v[2] = {12'h000, addr_w4};

    mem_dump_streamer #(.ADDR_W(16), .BASE_ADDR(32'hD51C), .NUM_BYTES(4), .SKIP_ZERO(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .mem_rd_en(rd_v[0]), .mem_addr(addr_v[0]), .mem_rdata(rdata_v[0]),
        .tx_data(data_v[0]), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]), .dbg_state(st_v[0])
    );

    mem_dump_streamer #(.ADDR_W(16), .BASE_ADDR(0), .NUM_BYTES(4), .SKIP_ZERO(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .mem_rd_en(rd_v[1]), .mem_addr(addr_v[1]), .mem_rdata(rdata_v[1]),
        .tx_data(data_v[1]), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]), .dbg_state(st_v[1])
    );

    mem_dump_streamer #(.ADDR_W(4), .BASE_ADDR(32'hE), .NUM_BYTES(3), .SKIP_ZERO(1'b0)) u_dut_w (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .mem_rd_en(rd_v[2]), .mem_addr(addr_w4), .mem_rdata(rdata_v[2]),
        .tx_data(data_v[2]), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]), .dbg_state(st_v[2])
    );

    // Synchronous-read memories: data appears the cycle after the strobe.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rd_v[k]) rdata_v[k] <= mem_v[k][addr_v[k]];
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Builds the expected text into exp_q; returns the busy cycle count at full sink speed.
    function automatic int build_exp(input int k);
        string s;
        int unsigned a;
        logic [7:0] v;
        int cyc;
        exp_q.delete();
        s = "Address,Value\n";
        for (int j = 0; j < s.len(); j++) exp_q.push_back(s[j]);
        cyc = 14;
        for (int i = 0; i < C_N[k]; i++) begin
            a = (C_BASE[k] + i) % (32'd1 << C_AW[k]);
            v = mem_v[k][a];
            if (C_SKIP[k] && v == 8'h00) begin
                cyc += 2;
            end else begin
                cyc += 18;
                s = $sformatf("0x%08x,0x%02x\n", a, v);
                for (int j = 0; j < s.len(); j++) exp_q.push_back(s[j]);
            end
        end
        return cyc;
    endfunction

    task automatic fill_rand(input int k, input int zero_pct);
        int unsigned a;
        for (int i = 0; i < C_N[k]; i++) begin
            a = (C_BASE[k] + i) % (32'd1 << C_AW[k]);
            if ($urandom_range(0, 99) < zero_pct) mem_v[k][a] = 8'h00;
            else mem_v[k][a] = 8'($urandom_range(1, 255));
        end
    endtask

    task automatic run_dump(input int k, input int rdy_pct, input bit spam, input int abort_at);
        logic [7:0] got_q[$];
        int dones = 0, rds = 0, busy_cyc = 0, busy_gap = 0, stall_err = 0, cyc = 0, exp_cyc;
        bit stalled = 1'b0, fin = 1'b0, aborted = 1'b0;
        logic [7:0] last_data = 8'h00;
        exp_cyc = build_exp(k);
        @(negedge clk);
        start_v[k] = 1'b1;
        ready_v[k] = 1'b1;
        while (!fin && !aborted && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (stalled && (!valid_v[k] || data_v[k] !== last_data)) stall_err++;
            if (rd_v[k]) rds++;
            if (done_v[k]) begin
                dones++;
                fin = 1'b1;
                if (busy_v[k]) busy_gap++;
            end else if (busy_v[k]) begin
                busy_cyc++;
            end else begin
                busy_gap++;
            end
            start_v[k] = spam && !fin;
            ready_v[k] = ($urandom_range(0, 99) < rdy_pct);
            stalled   = valid_v[k] && !ready_v[k];
            last_data = data_v[k];
            if (valid_v[k] && ready_v[k]) got_q.push_back(data_v[k]);
            if (abort_at > 0 && got_q.size() == abort_at) aborted = 1'b1;
        end
        start_v[k] = 1'b0;
        if (aborted) begin
            rst = 1'b1;
            #1;
            check("rst_tx_valid", valid_v[k], 0);
            check("rst_busy", busy_v[k], 0);
            check("rst_done", done_v[k], 0);
            check("rst_rd_en", rd_v[k], 0);
            check("rst_tx_data", data_v[k], 0);
            check("rst_mem_addr", addr_v[k], 0);
            for (int i = 0; i < got_q.size(); i++) check($sformatf("pre_rst_byte%0d", i), got_q[i], exp_q[i]);
            @(negedge clk);
            rst = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done_v[k]) dones++;
                if (valid_v[k]) stall_err++;
            end
            check("rst_no_done", dones, 0);
            check("rst_stays_idle", stall_err, 0);
        end else begin
            check("dump_timeout", fin, 1);
            repeat (20) begin
                @(negedge clk);
                if (done_v[k]) dones++;
            end
            check("done_count", dones, 1);
            check("rd_en_count", rds, C_N[k]);
            check("stall_stable", stall_err, 0);
            check("busy_gap", busy_gap, 0);
            if (rdy_pct >= 100) check("busy_cycles", busy_cyc, exp_cyc);
            check("stream_len", got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_v = '0;
        ready_v = '0;
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 65536; a++) mem_v[k][a] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_busy%0d", k), busy_v[k], 0);
            check($sformatf("reset_done%0d", k), done_v[k], 0);
            check($sformatf("reset_valid%0d", k), valid_v[k], 0);
            check($sformatf("reset_rd_en%0d", k), rd_v[k], 0);
            check($sformatf("reset_data%0d", k), data_v[k], 0);
            check($sformatf("reset_addr%0d", k), addr_v[k], 0);
        end
        rst = 1'b0;
        // Idle with sink ready: nothing may appear.
        ready_v = '1;
        repeat (5) @(negedge clk);
        check("idle_valid", valid_v[0], 0);

        mem_v[0][16'hD51C] = 8'h09;
        mem_v[0][16'hD51D] = 8'h71;
        mem_v[0][16'hD51E] = 8'h68;
        mem_v[0][16'hD51F] = 8'h29;
        run_dump(0, 100, 1'b0, 0);
        run_dump(0, 50, 1'b0, 0);
        run_dump(0, 100, 1'b1, 0);
        run_dump(0, 100, 1'b0, 35);
        run_dump(0, 100, 1'b0, 0);
        for (int r = 0; r < 4; r++) begin
            fill_rand(0, 10);
            run_dump(0, $urandom_range(30, 100), 1'($urandom_range(0, 1)), 0);
        end

        mem_v[1][0] = 8'h00;
        mem_v[1][1] = 8'hFF;
        mem_v[1][2] = 8'h00;
        mem_v[1][3] = 8'h00;
        run_dump(1, 100, 1'b0, 0);
        for (int a = 0; a < 4; a++) mem_v[1][a] = 8'h00;
        run_dump(1, 100, 1'b0, 0);
        for (int r = 0; r < 4; r++) begin
            fill_rand(1, 50);
            run_dump(1, $urandom_range(30, 100), 1'b0, 0);
        end

        for (int r = 0; r < 3; r++) begin
            fill_rand(2, 0);
            run_dump(2, (r == 0) ? 100 : 40, 1'(r == 2), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
